puf_response_collector: RTL

Automated challenge sweeper and response collector that sits around the `rng_puf` arbiter core. It steps the challenge from a base value, arms and clears the PUF for each evaluation, and captures the race result (`cnt1_greater` at finish) into a 64-bit response word. It hands the packed word to the UART framing stage through a valid/ready handshake. This replaces manual button-driven challenge stepping.

---
 rtl/puf_response_collector.sv | 108 ++++++++++
 1 files changed

// File: rtl/puf_response_collector.sv
// puf_response_collector: sweeps PUF challenges from a base value and packs each race result into a response word.
// Define PUF_COLLECT_MAJORITY_EN to evaluate every challenge three times and store the majority vote.
module puf_response_collector #(
  parameter int RESP_BITS = 64,
  parameter int CHAL_W = 10,
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                 CLK100MHZ,
  input  logic                 counter_reset,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    base_challenge,
  input  logic                 cnt1_finish,
  input  logic                 cnt2_finish,
  input  logic                 cnt1_greater,
  output logic [CHAL_W-1:0]    challenge,
  output logic                 puf_en,
  output logic                 puf_clear,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [6:0]           bit_count
);
`ifdef PUF_COLLECT_MAJORITY_EN
  localparam logic [1:0] LAST_EVAL = 2'd2;
`else
  localparam logic [1:0] LAST_EVAL = 2'd0;
`endif
  localparam int CW = $clog2((SETTLE_CYCLES > TIMEOUT_CYCLES ? SETTLE_CYCLES : TIMEOUT_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, RUN, CAPTURE, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] eval_n, ones;
  logic finish, vote, last_eval, last_bit;
  assign finish = cnt1_finish | cnt2_finish;
  assign vote = ones > (LAST_EVAL >> 1);
  assign last_eval = eval_n == LAST_EVAL;
  assign last_bit = bit_count == 7'(RESP_BITS - 1);
  always_ff @(posedge CLK100MHZ or posedge counter_reset) begin
    if (counter_reset) begin
      state <= IDLE;
      cnt <= '0;
      eval_n <= '0;
      ones <= '0;
      challenge <= '0;
      puf_en <= 1'b0;
      puf_clear <= 1'b0;
      resp_data <= '0;
      resp_valid <= 1'b0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      bit_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          challenge <= base_challenge;
          resp_data <= '0;
          bit_count <= '0;
          timeout_err <= 1'b0;
          eval_n <= '0;
          ones <= '0;
          puf_clear <= 1'b1;
          busy <= 1'b1;
          state <= CLEAR;
        end
        CLEAR: begin
          puf_clear <= 1'b0;
          cnt <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= (cnt == CW'(SETTLE_CYCLES - 1)) ? '0 : cnt + CW'(1);
          puf_en <= cnt == CW'(SETTLE_CYCLES - 1);
          state <= (cnt == CW'(SETTLE_CYCLES - 1)) ? RUN : SETTLE;
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          // a timed-out evaluation votes 0; a real finish wins if both land together
          if (finish || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            puf_en <= 1'b0;
            ones <= ones + {1'b0, finish & cnt1_greater};
            timeout_err <= timeout_err | ~finish;
            eval_n <= last_eval ? 2'd0 : eval_n + 2'd1;
            puf_clear <= ~last_eval;
            state <= last_eval ? CAPTURE : CLEAR;
          end
        end
        CAPTURE: begin
          resp_data <= resp_data | (RESP_BITS'(vote) << bit_count);
          ones <= '0;
          bit_count <= bit_count + 7'd1;
          challenge <= challenge + CHAL_W'(1);
          puf_clear <= ~last_bit;
          resp_valid <= last_bit;
          state <= last_bit ? DONE : CLEAR;
        end
        DONE: if (resp_ready) begin
          resp_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
